// File: rtl/vram_blitter_if.sv
// Host-side bundle for the sprite blitter: copy command, status, sprite ROM port and VRAM write port.
interface vram_blitter_if #(
    parameter int SPR_AW = 12
);
    logic                start;
    logic signed [9:0]   x0;
    logic signed [8:0]   y0;
    logic [5:0]          w;
    logic [5:0]          h;
    logic [SPR_AW-1:0]   spr_base;
    logic                busy;
    logic                done;
    logic [SPR_AW-1:0]   spr_addr;
    logic [12:0]         spr_data;
    logic                wr_allow;
    logic                wr_en;
    logic [14:0]         wr_addr;
    logic [12:0]         wr_data;

    modport master (
        output start, x0, y0, w, h, spr_base, spr_data, wr_allow,
        input  busy, done, spr_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, x0, y0, w, h, spr_base, spr_data, wr_allow,
        output busy, done, spr_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/vram_blitter.sv
// Copies a w x h sprite from a synchronous ROM into the framebuffer, clipping at screen
// edges, skipping transparent pixels and holding opaque writes until wr_allow is high.
module vram_blitter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int SPR_AW = 12
) (
    input  logic           clk,
    input  logic           rst,
    vram_blitter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t              state_reg;
    logic signed [9:0]   x0_reg;
    logic signed [8:0]   y0_reg;
    logic [5:0]          w_reg;
    logic [5:0]          h_reg;
    logic [5:0]          col_reg;
    logic [5:0]          row_reg;
    logic [SPR_AW-1:0]   spr_addr_reg;
    logic                busy_reg;
    logic                done_reg;

    logic [10:0]         px;
    logic [10:0]         py;
    logic                inb;
    logic                want;
    logic                advance;
    logic                last_col;
    logic                last_row;

    // Screen coordinates are 11-bit two's complement; a set sign bit means off-screen.
    always_comb begin
        px       = {x0_reg[9], x0_reg} + {5'd0, col_reg};
        py       = {{2{y0_reg[8]}}, y0_reg} + {5'd0, row_reg};
        inb      = !px[10] && (px[9:0] < 10'(FB_W)) && !py[10] && (py[9:0] < 10'(FB_H));
        want     = inb && bus.spr_data[0];
        advance  = (state_reg == WRITE) && !(want && !bus.wr_allow);
        last_col = (col_reg == w_reg - 6'd1);
        last_row = (row_reg == h_reg - 6'd1);
    end

    assign bus.wr_en    = (state_reg == WRITE) && want && bus.wr_allow;
    assign bus.wr_addr  = 15'(py[6:0]) * 15'(FB_W) + 15'(px[7:0]);
    assign bus.wr_data  = bus.spr_data;
    assign bus.spr_addr = spr_addr_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;

    // spr_addr_reg doubles as the linear ROM pointer; it is held through WRITE so
    // the ROM output stays stable during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            x0_reg       <= '0;
            y0_reg       <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            spr_addr_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        x0_reg       <= bus.x0;
                        y0_reg       <= bus.y0;
                        w_reg        <= bus.w;
                        h_reg        <= bus.h;
                        col_reg      <= '0;
                        row_reg      <= '0;
                        spr_addr_reg <= bus.spr_base;
                        if (bus.w == 6'd0 || bus.h == 6'd0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= READ;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state_reg <= WRITE;
                end
                WRITE: begin
                    if (advance) begin
                        if (last_col) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 6'd1;
                        end else begin
                            col_reg <= col_reg + 6'd1;
                        end
                        if (last_col && last_row) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg    <= READ;
                            spr_addr_reg <= spr_addr_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule
